// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack-machine controller: state encoding,
// opcode and ALU operation constants, and the packed control vector.
package stack_ctrl_pkg;

    localparam logic [3:0] ST_IF    = 4'd0;
    localparam logic [3:0] ST_ID    = 4'd1;
    localparam logic [3:0] ST_POPA  = 4'd2;
    localparam logic [3:0] ST_POPB  = 4'd3;
    localparam logic [3:0] ST_EXEC  = 4'd4;
    localparam logic [3:0] ST_WB    = 4'd5;
    localparam logic [3:0] ST_MRD   = 4'd6;
    localparam logic [3:0] ST_MPUSH = 4'd7;
    localparam logic [3:0] ST_MWR   = 4'd8;
    localparam logic [3:0] ST_JZCHK = 4'd9;

    typedef enum logic [3:0] {
        S_IF    = ST_IF,
        S_ID    = ST_ID,
        S_POPA  = ST_POPA,
        S_POPB  = ST_POPB,
        S_EXEC  = ST_EXEC,
        S_WB    = ST_WB,
        S_MRD   = ST_MRD,
        S_MPUSH = ST_MPUSH,
        S_MWR   = ST_MWR,
        S_JZCHK = ST_JZCHK
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       m_to_s;
        logic       ld_a;
        logic       ld_b;
        logic       src_a;
        logic       src_b;
        logic       push;
        logic       pop;
        logic       tos;
        logic [1:0] alu_op;
    } ctrl_t;

    // Two-operand arithmetic/logic instructions pop both A and B.
    function automatic logic is_binop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    // ALU operation used in EXEC for each arithmetic opcode.
    function automatic logic [1:0] alu_op_for(input logic [2:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_NOT:  return ALU_NOT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/stack_ctrl_outdec.sv
// Control-vector decoder: maps the current FSM state (plus opcode in ID and
// EXEC) onto every datapath strobe. Purely combinational.
module stack_ctrl_outdec
    import stack_ctrl_pkg::*;
#(
    parameter int OPW = 3
) (
    input  state_e         state,
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl
);

    // Moore decode; anything not set for a state stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = 1'b1;
                ctrl.src_a    = 1'b1;
                ctrl.src_b    = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                ctrl.pc_write = 1'b1;
            end
            S_ID: begin
                if (opcode == OP_JMP) begin
                    ctrl.pc_src   = 1'b1;
                    ctrl.pc_write = 1'b1;
                end else if (opcode == OP_JZ) begin
                    ctrl.tos = 1'b1;
                end
            end
            S_POPA: begin
                ctrl.pop  = 1'b1;
                ctrl.ld_a = 1'b1;
            end
            S_POPB: begin
                ctrl.pop  = 1'b1;
                ctrl.ld_b = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_op = alu_op_for(opcode);
            end
            S_WB: begin
                ctrl.push = 1'b1;
            end
            S_MRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MPUSH: begin
                ctrl.m_to_s = 1'b1;
                ctrl.push   = 1'b1;
            end
            S_MWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_JZCHK: begin
                ctrl.pc_src        = 1'b1;
                ctrl.pc_write_cond = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_controller.sv
// Multi-cycle fetch/decode/execute controller for the stack-machine datapath.
// Optional build macro STACK_CTRL_PERF_EN adds a saturating retired-instruction
// counter on port instr_cnt; the FSM is identical either way.
//
// state | meaning
// IF    | fetch instruction, PC <= PC+1
// ID    | decode; JMP loads PC here, JZ presents stack top
// POPA  | pop operand into A
// POPB  | pop operand into B
// EXEC  | ALU operates on A,B
// WB    | push ALU result
// MRD   | read memory at IR[4:0]
// MPUSH | push MDR
// MWR   | write A to memory at IR[4:0]
// JZCHK | conditional PC load on zero flag
module stack_controller
    import stack_ctrl_pkg::*;
#(
    parameter int OPW = 3
`ifdef STACK_CTRL_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    output logic           pcWrite,
    output logic           pcWriteCond,
    output logic           pcSrc,
    output logic           IorD,
    output logic           memRead,
    output logic           memWrite,
    output logic           IRWrite,
    output logic           MtoS,
    output logic           ldA,
    output logic           ldB,
    output logic           srcA,
    output logic           srcB,
    output logic           push,
    output logic           pop,
    output logic           tos,
    output logic [1:0]     ALUOp
`ifdef STACK_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_e state_q, state_d;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:    state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_PUSH: state_d = S_MRD;
                    OP_JMP:  state_d = S_IF;
                    OP_JZ:   state_d = S_JZCHK;
                    default: state_d = S_POPA;
                endcase
            end
            S_POPA: begin
                if (is_binop(opcode))       state_d = S_POPB;
                else if (opcode == OP_NOT)  state_d = S_EXEC;
                else                        state_d = S_MWR;
            end
            S_POPB:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IF;
            S_MRD:   state_d = S_MPUSH;
            S_MPUSH: state_d = S_IF;
            S_MWR:   state_d = S_IF;
            S_JZCHK: state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // State register with synchronous reset back to fetch.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IF;
        else      state_q <= state_d;
    end

    stack_ctrl_outdec #(.OPW(OPW)) u_outdec (
        .state  (state_q),
        .opcode (opcode),
        .ctrl   (ctrl_raw)
    );

    // Reset holds every strobe low immediately, so an abandoned instruction
    // never leaks a partial strobe in the reset cycle.
    always_comb begin
        ctrl = rst ? ctrl_raw : '0;
    end

    assign pcWrite     = ctrl.pc_write;
    assign pcWriteCond = ctrl.pc_write_cond;
    assign pcSrc       = ctrl.pc_src;
    assign IorD        = ctrl.iord;
    assign memRead     = ctrl.mem_read;
    assign memWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MtoS        = ctrl.m_to_s;
    assign ldA         = ctrl.ld_a;
    assign ldB         = ctrl.ld_b;
    assign srcA        = ctrl.src_a;
    assign srcB        = ctrl.src_b;
    assign push        = ctrl.push;
    assign pop         = ctrl.pop;
    assign tos         = ctrl.tos;
    assign ALUOp       = ctrl.alu_op;

`ifdef STACK_CTRL_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // Every path back into IF from a non-IF state ends an instruction.
    always_comb begin
        retire = (state_d == S_IF) && (state_q != S_IF);
        cnt_d  = cnt_q;
        if (retire && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign instr_cnt = rst ? cnt_q : '0;
`endif

    a_push_pop_excl: assert property (@(posedge clk) !(push && pop));
    a_mem_rw_excl:   assert property (@(posedge clk) !(memRead && memWrite));
    a_state_valid:   assert property (@(posedge clk) disable iff (!rst)
        state_q inside {S_IF, S_ID, S_POPA, S_POPB, S_EXEC, S_WB,
                        S_MRD, S_MPUSH, S_MWR, S_JZCHK});

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: directed literal checks plus random instruction
// streams (with random mid-instruction resets) against a per-instruction
// step-list model.
module tb_stack_controller;

    localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_AND = 3'd2, T_NOT = 3'd3;
    localparam logic [2:0] T_PUSH = 3'd4, T_POP = 3'd5, T_JMP = 3'd6, T_JZ = 3'd7;

    // Bit positions in the packed observation vector.
    localparam int B_PCW = 16, B_PCWC = 15, B_PCSRC = 14, B_IORD = 13, B_MRD = 12;
    localparam int B_MWR = 11, B_IRW = 10, B_MTOS = 9, B_LDA = 8, B_LDB = 7;
    localparam int B_SRCA = 6, B_SRCB = 5, B_PUSH = 4, B_POP = 3, B_TOS = 2;

    localparam int P_IF = 0, P_ID = 1, P_POPA = 2, P_POPB = 3, P_EXEC = 4;
    localparam int P_WB = 5, P_MRD = 6, P_MPUSH = 7, P_MWR = 8, P_JZCHK = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
    logic ldA, ldB, srcA, srcB, push, pop, tos;
    logic [1:0] ALUOp;
`ifdef STACK_CTRL_PERF_EN
    localparam int CW = 4;
    logic [CW-1:0] instr_cnt;
`endif

    stack_controller #(
        .OPW(3)
`ifdef STACK_CTRL_PERF_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
        .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB),
        .push(push), .pop(pop), .tos(tos), .ALUOp(ALUOp)
`ifdef STACK_CTRL_PERF_EN
        , .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [16:0] dv;
    assign dv = {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS,
                 ldA, ldB, srcA, srcB, push, pop, tos, ALUOp};

    int tests = 0;
    int fails = 0;

    function automatic int seq_len(input logic [2:0] op);
        case (op)
            T_ADD, T_SUB, T_AND: return 6;
            T_NOT:               return 5;
            T_PUSH, T_POP:       return 4;
            T_JMP:               return 2;
            default:             return 3;
        endcase
    endfunction

    function automatic int step_name(input logic [2:0] op, input int idx);
        if (idx == 0) return P_IF;
        if (idx == 1) return P_ID;
        case (op)
            T_ADD, T_SUB, T_AND: begin
                case (idx)
                    2: return P_POPA;
                    3: return P_POPB;
                    4: return P_EXEC;
                    default: return P_WB;
                endcase
            end
            T_NOT: begin
                case (idx)
                    2: return P_POPA;
                    3: return P_EXEC;
                    default: return P_WB;
                endcase
            end
            T_PUSH:  return (idx == 2) ? P_MRD : P_MPUSH;
            T_POP:   return (idx == 2) ? P_POPA : P_MWR;
            default: return P_JZCHK;
        endcase
    endfunction

    function automatic logic [16:0] exp_vec(input logic [2:0] op, input int idx);
        logic [16:0] v;
        v = '0;
        case (step_name(op, idx))
            P_IF: begin
                v[B_MRD] = 1'b1; v[B_IRW] = 1'b1; v[B_SRCA] = 1'b1;
                v[B_SRCB] = 1'b1; v[B_PCW] = 1'b1;
            end
            P_ID: begin
                if (op == T_JMP) begin v[B_PCSRC] = 1'b1; v[B_PCW] = 1'b1; end
                if (op == T_JZ) v[B_TOS] = 1'b1;
            end
            P_POPA:  begin v[B_POP] = 1'b1; v[B_LDA] = 1'b1; end
            P_POPB:  begin v[B_POP] = 1'b1; v[B_LDB] = 1'b1; end
            P_EXEC:  v[1:0] = op[1:0];
            P_WB:    v[B_PUSH] = 1'b1;
            P_MRD:   begin v[B_IORD] = 1'b1; v[B_MRD] = 1'b1; end
            P_MPUSH: begin v[B_MTOS] = 1'b1; v[B_PUSH] = 1'b1; end
            P_MWR:   begin v[B_IORD] = 1'b1; v[B_MWR] = 1'b1; end
            default: begin v[B_PCSRC] = 1'b1; v[B_PCWC] = 1'b1; end
        endcase
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Model: position within the current instruction's step list.
    int mstep = 0;
`ifdef STACK_CTRL_PERF_EN
    int mcnt = 0;
`endif

    // Compare process: every cycle, DUT outputs vs the step-list model.
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            e = '0;
            mstep = 0;
`ifdef STACK_CTRL_PERF_EN
            mcnt = 0;
`endif
        end else begin
            e = exp_vec(opcode, mstep);
        end
        tests++;
        if (dv !== e) begin
            fails++;
            $display("FAIL model_vec: got %h want %h op=%0d step=%0d t=%0t",
                     dv, e, opcode, mstep, $time);
        end
`ifdef STACK_CTRL_PERF_EN
        tests++;
        if (instr_cnt !== CW'(mcnt)) begin
            fails++;
            $display("FAIL model_cnt: got %0d want %0d t=%0t", instr_cnt, mcnt, $time);
        end
`endif
        if (rst) begin
            if (mstep == seq_len(opcode) - 1) begin
                mstep = 0;
`ifdef STACK_CTRL_PERF_EN
                if (mcnt < (1 << CW) - 1) mcnt++;
`endif
            end else begin
                mstep++;
            end
        end
    end

    logic [16:0] seen [1:6];

    // Entered at posedge+1 of an IF cycle; leaves at posedge+1 of the next IF.
    // abort_at>0 pulls reset low for one cycle during that step.
    task automatic instr(input logic [2:0] op, input int abort_at);
        opcode = op;
        for (int k = 1; k <= seq_len(op); k++) begin
            if (k == abort_at) rst = 1'b0;
            @(negedge clk);
            seen[k] = dv;
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                rst = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        opcode = T_ADD;
        repeat (3) begin
            @(negedge clk);
            chk("reset_all_zero", 32'(dv), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        instr(T_ADD, 0);
        chk("first_if_memRead", 32'(seen[1][B_MRD]), 32'h1);
        chk("first_if_IRWrite", 32'(seen[1][B_IRW]), 32'h1);
        chk("first_if_pcWrite", 32'(seen[1][B_PCW]), 32'h1);
        chk("add_exec_vec", 32'(seen[5]), 32'h0);
        chk("add_wb_vec", 32'(seen[6]), 32'h10);

        instr(T_PUSH, 0);
        chk("add_back_in_if_c7", 32'(seen[1]), 32'h11460);
        chk("push_mrd_vec", 32'(seen[3]), 32'h3000);
        chk("push_mpush_vec", 32'(seen[4]), 32'h210);

        instr(T_JMP, 0);
        chk("push_back_in_if_c5", 32'(seen[1]), 32'h11460);
        chk("jmp_id_vec", 32'(seen[2]), 32'h14000);
`ifdef STACK_CTRL_PERF_EN
        chk("cnt_after_3", 32'(instr_cnt), 32'd3);
`endif

        instr(T_JZ, 0);
        chk("jz_id_tos", 32'(seen[2]), 32'h4);
        chk("jz_chk_vec", 32'(seen[3]), 32'hC000);

        instr(T_SUB, 4);
        chk("sub_popa_vec", 32'(seen[3]), 32'h108);
        chk("sub_reset_in_popb", 32'(seen[4]), 32'h0);

        instr(T_JMP, 0);
        chk("after_abort_if", 32'(seen[1]), 32'h11460);
        chk("after_abort_no_push", 32'(seen[2][B_PUSH]), 32'h0);
`ifdef STACK_CTRL_PERF_EN
        chk("cnt_after_reset_jmp", 32'(instr_cnt), 32'd1);
        repeat (20) instr(3'($urandom_range(0, 7)), 0);
        chk("cnt_saturated", 32'(instr_cnt), 32'((1 << CW) - 1));
`endif

        repeat (300) begin
            logic [2:0] op;
            int ab;
            op = 3'($urandom_range(0, 7));
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, seq_len(op))) : 0;
            instr(op, ab);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
